// File: rtl/mine_pkg.sv
// Shared types and constants for the minesweeper mine placer and board.
// Cell indices are {row, col} on an 8x8 board.
package mine_pkg;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 8;

    // Fibonacci taps at bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        ISSUE,
        DONE
    } placer_state_t;

    typedef enum logic [1:0] {
        HIDDEN,
        REVEALED,
        FLAG,
        BOMB
    } cell_state_t;

    function automatic logic [5:0] cell_idx(
        input logic [2:0] r,
        input logic [2:0] c
    );
        return {r, c};
    endfunction

endpackage

// File: rtl/mine_placer_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR with seed load.
// A zero load value falls back to the default seed so it never locks up.
module lfsr16
    import mine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic [15:0] default_seed,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAPS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= default_seed;
        end else if (load) begin
            value <= (load_value == 16'h0000) ? default_seed : load_value;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/mine_placer.sv
// Issues up to 15 distinct pseudo-random mine coordinates per run,
// optionally keeping one safe cell free of mines.
module mine_placer
    import mine_pkg::*;
#(
    parameter int          ROWS      = BOARD_ROWS,
    parameter int          COLS      = BOARD_COLS,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  total_mines,
    input  logic [15:0] seed,
    input  logic        seed_load,
    input  logic        safe_en,
    input  logic [2:0]  safe_row,
    input  logic [2:0]  safe_col,
    output logic        place_mine,
    output logic [2:0]  row,
    output logic [2:0]  column,
    output logic        busy,
    output logic        done,
    output logic [3:0]  placed_count
);

    localparam int CELLS = ROWS * COLS;

    placer_state_t    state;
    logic [CELLS-1:0] occupied;
    logic [3:0]       total_q;
    logic             safe_en_q;
    logic [2:0]       safe_row_q;
    logic [2:0]       safe_col_q;

    logic [15:0] lfsr;
    logic        idle_like;
    logic [2:0]  cand_row;
    logic [2:0]  cand_col;
    logic        cand_safe;
    logic        reject;
    logic [3:0]  next_count;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign cand_row   = lfsr[5:3];
    assign cand_col   = lfsr[2:0];
    assign cand_safe  = safe_en_q
                     && (cand_row == safe_row_q)
                     && (cand_col == safe_col_q);
    assign reject     = occupied[cell_idx(cand_row, cand_col)] | cand_safe;
    assign next_count = placed_count + 4'd1;

    // Seed loads are only honoured between runs
    lfsr16 u_lfsr (
        .clk          (clk),
        .reset        (reset),
        .load         (seed_load & idle_like),
        .load_value   (seed),
        .default_seed (LFSR_SEED),
        .value        (lfsr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            occupied     <= '0;
            total_q      <= '0;
            safe_en_q    <= 1'b0;
            safe_row_q   <= '0;
            safe_col_q   <= '0;
            place_mine   <= 1'b0;
            row          <= '0;
            column       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            placed_count <= '0;
        end else begin
            place_mine <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        total_q      <= total_mines;
                        safe_en_q    <= safe_en;
                        safe_row_q   <= safe_row;
                        safe_col_q   <= safe_col;
                        occupied     <= '0;
                        placed_count <= '0;
                        if (total_mines == 4'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= GEN;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                GEN: begin
                    if (!reject) begin
                        row        <= cand_row;
                        column     <= cand_col;
                        place_mine <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    occupied[cell_idx(row, column)] <= 1'b1;
                    placed_count <= next_count;
                    if (next_count == total_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= GEN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mine_placer.md
# mine_placer

Random mine-placement engine for the minesweeper board. On a start pulse it generates up to `total_mines` distinct pseudo-random cell coordinates and issues each one as a single-cycle `place_mine` strobe with `row`/`column`. It drives the board's mine-placement port, which counts accepted mines and then computes adjacency. It never issues a duplicate coordinate, and it can keep one safe cell mine-free so the first click is never a bomb.

## Interface
- `ROWS`, default 8: board rows. The row index is 3 bits.
- `COLS`, default 8: board columns. The column index is 3 bits.
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset, and the substitute whenever a zero seed is loaded.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a placement run. Sampled only in IDLE or DONE.
- `total_mines`  in  4: mines to place (0..15). Latched on an accepted `start`.
- `seed`  in  16: LFSR seed value.
- `seed_load`  in  1: load `seed` into the LFSR. Honoured only in IDLE or DONE.
- `safe_en`  in  1: enable the safe-cell exclusion. Latched on `start`.
- `safe_row`  in  3: safe-cell row. Latched on `start`.
- `safe_col`  in  3: safe-cell column. Latched on `start`.
- `place_mine`  out  1: one-cycle strobe marking a new mine coordinate.
- `row`  out  3: mine row. Valid when `place_mine`=1.
- `column`  out  3: mine column. Valid when `place_mine`=1.
- `busy`  out  1: high in GEN and ISSUE.
- `done`  out  1: high in DONE, held until the next accepted `start`.
- `placed_count`  out  4: mines issued in the current run.

## Operation
- States: IDLE, GEN, ISSUE, DONE.
- IDLE/DONE + `start`:
  - Latch `total_mines`, `safe_*`.
  - Clear the 64-bit occupancy map and `placed_count`.
  - Drop `done`.
  - Go to GEN, or straight to DONE if `total_mines`==0.
- GEN:
  - Candidate = `lfsr[5:3]` as row, `lfsr[2:0]` as column, taken from the current LFSR value.
  - Reject the candidate if its occupancy bit is set, or if `safe_en` is set and the candidate equals the safe cell. On reject, stay in GEN; the LFSR has already advanced, so retry next cycle.
  - On accept, register the candidate into `row`/`column` and go to ISSUE.
- ISSUE:
  - `place_mine`=1 for exactly this cycle.
  - Set the occupancy bit and increment `placed_count`.
  - Next state is DONE if the new count equals the latched total, else GEN.
- LFSR:
  - 16-bit Fibonacci, shifts left, feedback `b15^b13^b12^b10`.
  - Advances every cycle outside reset, in every state.
- `seed_load` loads `seed` in place of the advance. A zero seed loads `LFSR_SEED`, so the LFSR can never lock up.
- `start` or `seed_load` while busy: ignored, no side effects.
- `start` and `seed_load` in the same cycle: the seed is loaded and the run starts. The first candidate comes from the loaded seed.
- Worst-case termination: 15 mines plus 1 safe cell is at most 16 of 64 cells, so a free cell always exists. Verify that the LFSR period of 65535 eventually hits every 6-bit pattern.

## Timing
- Reset values:
  - `place_mine`=0, `row`=0, `column`=0, `busy`=0, `done`=0, `placed_count`=0.
  - State IDLE, LFSR=`LFSR_SEED`, occupancy cleared.
- `start` accepted at edge N: GEN from N+1. The earliest `place_mine` is at cycle N+2.
- Minimum spacing between strobes is 2 cycles (GEN→ISSUE). Each rejected candidate adds 1 cycle.
- `done` and `busy`=0 are asserted the cycle after the final ISSUE.
- `row`/`column` hold their last value outside ISSUE.
- Reset asserted mid-run:
  - Immediate return to reset values.
  - A partially issued run is abandoned.
  - The board must be reset by the same system reset.

## Structure
- Package `mine_pkg`:
  - State enum `placer_state_t`.
  - `ROWS`/`COLS` constants.
  - LFSR tap mask.
  - Cell-state encodings shared with the board (HIDDEN, REVEALED, FLAG, BOMB).
  - Function `cell_idx(row,col)` returning `{row,col}`.
- Sub-module `lfsr16`:
  - Inputs: clock, reset, load, load value, default seed.
  - Output: current value.
  - Instantiated once.

## Test plan
- Reset, `seed_load` with 16'h0000, then `start` with `total_mines`=10 → exactly 10 `place_mine` pulses, all coordinates distinct, `placed_count`=10, `done`=1, `busy`=0.
- Same seed and same start cycle, run twice → identical coordinate sequence both times (determinism).
- `total_mines`=0 → `done` the cycle after `start`, no `place_mine` pulse.
- `safe_en`=1, safe cell (3,4), `total_mines`=15, 200 seeds → (3,4) never issued; 15 distinct coordinates per run.
- `start` pulsed again mid-run with `total_mines`=2 → ignored; the run completes the original 15.
- Reset deasserted-then-asserted after 4 pulses → outputs 0 at once. A new `start` with 3 yields 3 pulses, and the occupancy map does not carry old cells (verified by forcing seed 16'hACE1 both runs).
